// File: rtl/reg_file_sb.sv
// Register file: two async read ports, one sync write port, write bypass,
// load-busy scoreboard and a hardware clear sweep.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              clr_busy_q;

  logic idle;
  logic wr_ok;
  logic iss_ok;
  logic zero_a;
  logic zero_b;
  logic byp_a;
  logic byp_b;
  logic iss_a;
  logic iss_b;

  assign idle   = (state_q == S_IDLE);
  assign wr_ok  = we &&
                  !(ZERO_REG && (wr_addr == '0));
  assign iss_ok = issue_valid &&
                  !(ZERO_REG && (issue_addr == '0));

  // Per-port qualifiers for the read paths.
  always_comb begin
    zero_a = ZERO_REG && (ra_addr == '0);
    zero_b = ZERO_REG && (rb_addr == '0);
    byp_a  = BYPASS && idle && wr_ok &&
             (wr_addr == ra_addr);
    byp_b  = BYPASS && idle && wr_ok &&
             (wr_addr == rb_addr);
    iss_a  = idle && iss_ok &&
             (issue_addr == ra_addr);
    iss_b  = idle && iss_ok &&
             (issue_addr == rb_addr);
  end

  // Port A: zero reg, then bypass, then array.
  always_comb begin
    ra_data = mem_q[ra_addr];
    ra_busy = busy_q[ra_addr];
    unique case (1'b1)
      zero_a: begin
        ra_data = '0;
        ra_busy = 1'b0;
      end
      byp_a: begin
        ra_data = wr_data;
        ra_busy = iss_a;
      end
      default: ;
    endcase
  end

  // Port B: same priority as port A.
  always_comb begin
    rb_data = mem_q[rb_addr];
    rb_busy = busy_q[rb_addr];
    unique case (1'b1)
      zero_b: begin
        rb_data = '0;
        rb_busy = 1'b0;
      end
      byp_b: begin
        rb_data = wr_data;
        rb_busy = iss_b;
      end
      default: ;
    endcase
  end

  // Scoreboard next state: write clears, issue sets (issue wins),
  // entering the sweep clears everything.
  always_comb begin
    busy_d = busy_q;
    if (idle) begin
      if (wr_ok) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[issue_addr] = 1'b1;
      end
      if (clr_req) begin
        busy_d = '0;
      end
    end
  end

  // Busy bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Array: normal writes in IDLE, one entry zeroed per cycle in SWEEP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (idle) begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end else begin
      mem_q[idx_q] <= '0;
    end
  end

  // Sweep controller with registered clr_busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q    <= S_SWEEP;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        S_SWEEP: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q    <= S_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default instance plus a
// BYPASS=0 / ZERO_REG=0 instance driven by the same stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra_addr, rb_addr, wr_addr, issue_addr;
  logic [31:0] wr_data;
  logic        we, issue_valid, clr_req;

  logic [31:0] ra_data, rb_data, ra_data_n, rb_data_n;
  logic        ra_busy, rb_busy, ra_busy_n, rb_busy_n;
  logic        clr_busy, clr_busy_n;

  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .ra_busy(ra_busy), .rb_busy(rb_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  reg_file_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data_n), .rb_data(rb_data_n),
    .ra_busy(ra_busy_n), .rb_busy(rb_busy_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ra_addr = '0; rb_addr = '0;
    wr_addr = '0; wr_data = '0; we = 1'b0;
    issue_valid = 1'b0; issue_addr = '0;
    clr_req = 1'b0;
    tick; tick;
    rst = 1'b0;
    ra_addr = 5'd5; rb_addr = 5'd9;
    #1;
    chk("reset_ra", ra_data, 32'h0);
    chk("reset_busy", {30'b0, ra_busy, rb_busy}, 32'h0);
    chk("reset_clr", {31'b0, clr_busy}, 32'h0);

    // 1: async reset mid-cycle
    tick;
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick;
    we = 1'b0;
    #1;
    chk("wr_r5", ra_data, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    chk("arst_r5", ra_data, 32'h0);
    chk("arst_clr", {31'b0, clr_busy}, 32'h0);
    #1 rst = 1'b0;

    // 2: bypass
    tick;
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    ra_addr = 5'd7; rb_addr = 5'd7;
    #1;
    chk("byp_ra", ra_data, 32'h12345678);
    chk("byp_rb", rb_data, 32'h12345678);
    chk("nobyp_ra", ra_data_n, 32'h0);
    chk("nobyp_rb", rb_data_n, 32'h0);
    tick;
    we = 1'b0;
    #1;
    chk("nobyp_after", ra_data_n, 32'h12345678);

    // 3: zero register
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick;
    we = 1'b0; issue_valid = 1'b0;
    ra_addr = 5'd0;
    #1;
    chk("zero_data", ra_data, 32'h0);
    chk("zero_busy", {31'b0, ra_busy}, 32'h0);
    chk("nz_data", ra_data_n, 32'hFFFFFFFF);
    chk("nz_busy", {31'b0, ra_busy_n}, 32'h1);

    // 4: scoreboard
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick;
    issue_valid = 1'b0;
    ra_addr = 5'd9; rb_addr = 5'd9;
    #1;
    chk("sb_set_a", {31'b0, ra_busy}, 32'h1);
    chk("sb_set_b", {31'b0, rb_busy}, 32'h1);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
    issue_valid = 1'b1; issue_addr = 5'd9;
    #1;
    chk("sb_wi_comb", {31'b0, ra_busy}, 32'h1);
    chk("sb_wi_data", ra_data, 32'hA5);
    tick;
    we = 1'b0; issue_valid = 1'b0;
    #1;
    chk("sb_wi_after", {31'b0, ra_busy}, 32'h1);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h5A;
    #1;
    chk("sb_byp_busy", {31'b0, ra_busy}, 32'h0);
    chk("sb_byp_data", ra_data, 32'h5A);
    chk("sb_nobyp_busy", {31'b0, ra_busy_n}, 32'h1);
    tick;
    we = 1'b0;
    #1;
    chk("sb_clr_busy", {31'b0, ra_busy}, 32'h0);
    chk("sb_clr_data", ra_data, 32'h5A);
    chk("sb_clr_busy_n", {31'b0, ra_busy_n}, 32'h0);

    // 5: sweep
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick;
    end
    we = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd3;
    tick;
    issue_valid = 1'b0;
    ra_addr = 5'd31; rb_addr = 5'd3;
    #1;
    chk("fill_r31", ra_data, 32'd31);
    chk("fill_busy3", {31'b0, rb_busy}, 32'h1);
    clr_req = 1'b1;
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick;
    cnt = clr_busy ? 1 : 0;
    clr_req = 1'b1;
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD;
    issue_valid = 1'b1; issue_addr = 5'd2;
    ra_addr = 5'd2; rb_addr = 5'd4;
    #1;
    chk("sw_clr_busy", {31'b0, clr_busy}, 32'h1);
    chk("sw_nobyp", ra_data, 32'd2);
    chk("sw_wr_commit", rb_data, 32'h44);
    rb_addr = 5'd3;
    #1;
    chk("sw_busy_clr", {31'b0, rb_busy}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (i == 5) begin
        clr_req = 1'b0; we = 1'b0; issue_valid = 1'b0;
      end
      if (!clr_busy) break;
      cnt++;
    end
    chk("sw_len", cnt, 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i);
      #1;
      chk("sw_zero", ra_data, 32'h0);
      chk("sw_nobusy", {31'b0, ra_busy}, 32'h0);
    end
    ra_addr = 5'd0;
    #1;
    chk("sw_zero_n", ra_data_n, 32'h0);

    // 6: reset mid-sweep, restart from index 0
    tick;
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      tick;
    end
    we = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (10) tick;
    ra_addr = 5'd10; rb_addr = 5'd9;
    #1;
    chk("ms_r10", ra_data, 32'h10A);
    chk("ms_r9", rb_data, 32'h0);
    rb_addr = 5'd12;
    rst = 1'b1;
    #1;
    chk("ms_clr", {31'b0, clr_busy}, 32'h0);
    chk("ms_r10_rst", ra_data, 32'h0);
    chk("ms_r12_rst", rb_data, 32'h0);
    #1 rst = 1'b0;
    tick;
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
    tick;
    wr_addr = 5'd1; wr_data = 32'h66;
    tick;
    we = 1'b0;
    clr_req = 1'b1;
    ra_addr = 5'd0; rb_addr = 5'd1;
    tick;
    clr_req = 1'b0;
    cnt = clr_busy ? 1 : 0;
    #1;
    chk("rs_r0_keep", ra_data_n, 32'h55);
    tick;
    if (clr_busy) cnt++;
    chk("rs_r0_clr", ra_data_n, 32'h0);
    chk("rs_r1_keep", rb_data_n, 32'h66);
    tick;
    if (clr_busy) cnt++;
    chk("rs_r1_clr", rb_data_n, 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (!clr_busy) break;
      cnt++;
    end
    chk("rs_len", cnt, 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
